// File: rtl/am_radio_ctrl_multich.sv
// ---------------------------------------------------------------------------
// am_radio_ctrl_multich
//
// N-channel AM broadcast controller sitting between the PS register bus and
// the per-channel NCO/modulator chain. It holds the register file, a
// fail-safe watchdog and a broadcast FSM that ramps a shared gain up and
// down so transmissions start and stop without clicks. A watchdog timeout
// is a hard cut: the gain drops to zero on the next clock with no ramp.
//
// Register map (byte addresses):
//   0x00 CTRL     rw  [0] bcast_req, [4] wd_en, [5] wd_clear (write-1 pulse, reads 0)
//   0x04 STATUS   ro  [0] bcast_active, [1] wd_triggered, [2] wd_warning,
//                     [6:4] state, [31:16] ch_enable
//   0x08 CH_MASK  rw  [N-1:0]
//   0x0C COMMIT   wo  any write copies every shadow frequency to ch_freq
//   0x10+4*i      rw  shadow frequency of channel i (i < N)
//   anything else reads 0xDEADBEEF, writes are dropped
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   wr_en/addr/data   single-cycle register write, always accepted
//   rd_en/addr        register read request
//   rd_data/rd_valid  read response, exactly one cycle after rd_en
//   ch_freq           active frequencies, channel i at [32*i +: 32]
//   ch_enable         per-channel modulator enable
//   gain              shared output envelope gain
//   bcast_active      FSM is in ACTIVE
//   wd_triggered      fail-safe latched
//   wd_warning        watchdog count has passed 80% of the timeout
// ---------------------------------------------------------------------------
module am_radio_ctrl_multich #(
    parameter int unsigned NUM_CHANNELS   = 2,
    parameter int unsigned TIMEOUT_CYCLES = 625_000_000,
    parameter int unsigned GAIN_W         = 12,
    parameter int unsigned RAMP_STEP      = 1,
    parameter int unsigned FREQ_BASE      = 700_000,
    parameter int unsigned FREQ_SPACING   = 200_000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [7:0]                 wr_addr,
    input  logic [31:0]                wr_data,
    input  logic                       rd_en,
    input  logic [7:0]                 rd_addr,
    output logic [31:0]                rd_data,
    output logic                       rd_valid,
    output logic [32*NUM_CHANNELS-1:0] ch_freq,
    output logic [NUM_CHANNELS-1:0]    ch_enable,
    output logic [GAIN_W-1:0]          gain,
    output logic                       bcast_active,
    output logic                       wd_triggered,
    output logic                       wd_warning
);

    localparam logic [7:0] ADDR_CTRL   = 8'h00;
    localparam logic [7:0] ADDR_STATUS = 8'h04;
    localparam logic [7:0] ADDR_MASK   = 8'h08;
    localparam logic [7:0] ADDR_COMMIT = 8'h0C;

    localparam logic [GAIN_W-1:0] GMAX    = '1;
    localparam logic [GAIN_W:0]   STEP_W  = (GAIN_W + 1)'(RAMP_STEP);

    localparam int unsigned       CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam longint unsigned   WARN_L  = (64'(TIMEOUT_CYCLES) * 4) / 5;
    localparam logic [CNT_W-1:0]  WARN_AT = CNT_W'(WARN_L);
    localparam logic [CNT_W-1:0]  TRIG_AT = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RAMP_UP   = 3'd1,
        ST_ACTIVE    = 3'd2,
        ST_RAMP_DOWN = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    state_t                  state;
    logic                    bcast_req;
    logic                    wd_en;
    logic [NUM_CHANNELS-1:0] ch_mask;
    logic [31:0]             shadow_freq [NUM_CHANNELS];
    logic [CNT_W-1:0]        wd_cnt;

    // ---------------------------------------------------------------------
    // Write-side decode shared by the register file, watchdog and FSM
    // ---------------------------------------------------------------------
    logic                    ctrl_wr;
    logic                    wd_clear;
    logic                    wd_en_next;
    logic                    wd_hit;
    logic [CNT_W-1:0]        wd_cnt_next;
    logic [NUM_CHANNELS-1:0] mask_next;
    logic                    go;

    assign ctrl_wr    = wr_en && (wr_addr == ADDR_CTRL);
    assign wd_clear   = ctrl_wr && wr_data[5];
    assign wd_en_next = ctrl_wr ? wr_data[4] : wd_en;

    // Any bus write is a heartbeat; it beats a timeout landing on the same clock.
    assign wd_hit = wd_en && !wr_en && (wd_cnt >= TRIG_AT);

    assign wd_cnt_next = (wr_en || !wd_en) ? '0 :
                         wd_triggered      ? wd_cnt :
                                             wd_cnt + 1'b1;

    // A mask write takes effect on ch_enable in the same clock it lands.
    assign mask_next = (wr_en && (wr_addr == ADDR_MASK)) ? wr_data[NUM_CHANNELS-1:0] : ch_mask;

    assign go = bcast_req && (ch_mask != '0) && !wd_triggered;

    // ---------------------------------------------------------------------
    // Register file and frequency shadowing
    // ---------------------------------------------------------------------
    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values of its neighbours, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcast_req <= 1'b0;
            wd_en     <= 1'b1;
            ch_mask   <= '0;
            // NOTE: the shadow array is a handful of flops, not a RAM, so it
            // takes the async reset like any other register.
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                shadow_freq[i]      <= 32'(FREQ_BASE + i * FREQ_SPACING);
                ch_freq[32*i +: 32] <= 32'(FREQ_BASE + i * FREQ_SPACING);
            end
        end else if (wr_en) begin
            if (ctrl_wr) begin
                bcast_req <= wr_data[0];
                wd_en     <= wr_data[4];
            end
            if (wr_addr == ADDR_MASK) begin
                ch_mask <= wr_data[NUM_CHANNELS-1:0];
            end
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (wr_addr == ADDR_COMMIT) begin
                    ch_freq[32*i +: 32] <= shadow_freq[i];
                end
                if (wr_addr == 8'(16 + 4 * i)) begin
                    shadow_freq[i] <= wr_data;
                    // Nothing is on air in IDLE, so the new tuning goes straight through.
                    if (state == ST_IDLE) begin
                        ch_freq[32*i +: 32] <= wr_data;
                    end
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Watchdog
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt       <= '0;
            wd_warning   <= 1'b0;
            wd_triggered <= 1'b0;
        end else begin
            wd_cnt     <= wd_cnt_next;
            // Built from next-state values so the flag rises with the count itself.
            wd_warning <= wd_en_next && (wd_cnt_next >= WARN_AT);
            if (wd_clear) begin
                wd_triggered <= 1'b0;
            end else if (wd_hit) begin
                wd_triggered <= 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Broadcast FSM with gain ramp
    // ---------------------------------------------------------------------
    logic [GAIN_W:0]   gain_sum;
    logic [GAIN_W-1:0] gain_up;
    logic [GAIN_W-1:0] gain_dn;

    assign gain_sum = {1'b0, gain} + STEP_W;
    assign gain_up  = (gain_sum > {1'b0, GMAX}) ? GMAX : gain_sum[GAIN_W-1:0];
    assign gain_dn  = ({1'b0, gain} <= STEP_W) ? '0 : gain - STEP_W[GAIN_W-1:0];

    // The ramp end is detected on the value being loaded, so the state moves
    // on the same clock the gain reaches full scale or zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            gain         <= '0;
            ch_enable    <= '0;
            bcast_active <= 1'b0;
        end else begin
            // Outputs default to off; the on-air branches below override them.
            ch_enable    <= '0;
            bcast_active <= 1'b0;
            if (wd_triggered) begin
                state <= ST_FAULT;
                gain  <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (go) begin
                            state     <= ST_RAMP_UP;
                            ch_enable <= mask_next;
                        end
                    end
                    ST_RAMP_UP: begin
                        ch_enable <= mask_next;
                        if (!go) begin
                            state <= ST_RAMP_DOWN;
                        end else begin
                            gain <= gain_up;
                            if (gain_up == GMAX) begin
                                state        <= ST_ACTIVE;
                                bcast_active <= 1'b1;
                            end
                        end
                    end
                    ST_ACTIVE: begin
                        ch_enable <= mask_next;
                        if (!go) begin
                            state <= ST_RAMP_DOWN;
                        end else begin
                            bcast_active <= 1'b1;
                        end
                    end
                    ST_RAMP_DOWN: begin
                        if (go) begin
                            state     <= ST_RAMP_UP;
                            ch_enable <= mask_next;
                        end else begin
                            gain <= gain_dn;
                            if (gain_dn == '0) begin
                                state <= ST_IDLE;
                            end else begin
                                ch_enable <= mask_next;
                            end
                        end
                    end
                    ST_FAULT: begin
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                        gain  <= '0;
                    end
                endcase
            end
        end
    end

    // ---------------------------------------------------------------------
    // Read path: registered, so a same-cycle write is seen on the next read
    // ---------------------------------------------------------------------
    logic [31:0] rd_mux;
    logic [31:0] status_word;

    assign status_word = {16'(ch_enable), 9'b0, state, 1'b0, wd_warning, wd_triggered, bcast_active};

    always_comb begin
        // NOTE: defaulting the mux before the case keeps every path assigned,
        // so no latch is inferred for unmapped addresses.
        rd_mux = 32'hDEAD_BEEF;
        case (rd_addr)
            ADDR_CTRL:   rd_mux = {27'b0, wd_en, 3'b0, bcast_req};
            ADDR_STATUS: rd_mux = status_word;
            ADDR_MASK:   rd_mux = 32'(ch_mask);
            ADDR_COMMIT: rd_mux = '0;
            default: begin
                for (int i = 0; i < NUM_CHANNELS; i++) begin
                    if (rd_addr == 8'(16 + 4 * i)) begin
                        rd_mux = shadow_freq[i];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_am_radio_ctrl_multich.sv
// ---------------------------------------------------------------------------
// Testbench for am_radio_ctrl_multich (2 channels, 4-bit gain, 100-cycle
// watchdog). Directed sequences walk the ramp, watchdog and frequency
// shadowing scenarios, then a randomized phase mixes bus traffic. A
// behavioural model tracks the controller per clock; read responses go
// through an expected-data queue drained by an independent monitor.
// ---------------------------------------------------------------------------
module tb_am_radio_ctrl_multich;

    localparam int N     = 2;
    localparam int T     = 100;
    localparam int GW    = 4;
    localparam int STEP  = 1;
    localparam int FB    = 700_000;
    localparam int FS    = 200_000;
    localparam int GMAX  = (1 << GW) - 1;
    localparam int WARN  = T * 4 / 5;

    localparam int S_IDLE = 0, S_UP = 1, S_ACT = 2, S_DOWN = 3, S_FAULT = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wr_en;
    logic [7:0]        wr_addr;
    logic [31:0]       wr_data;
    logic              rd_en;
    logic [7:0]        rd_addr;
    logic [31:0]       rd_data;
    logic              rd_valid;
    logic [32*N-1:0]   ch_freq;
    logic [N-1:0]      ch_enable;
    logic [GW-1:0]     gain;
    logic              bcast_active;
    logic              wd_triggered;
    logic              wd_warning;

    am_radio_ctrl_multich #(
        .NUM_CHANNELS  (N),
        .TIMEOUT_CYCLES(T),
        .GAIN_W        (GW),
        .RAMP_STEP     (STEP),
        .FREQ_BASE     (FB),
        .FREQ_SPACING  (FS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .ch_freq     (ch_freq),
        .ch_enable   (ch_enable),
        .gain        (gain),
        .bcast_active(bcast_active),
        .wd_triggered(wd_triggered),
        .wd_warning  (wd_warning)
    );

    always #5 clk = ~clk;

    // ---------------- reference model state ----------------
    int          m_state, m_gain, m_mask, m_req, m_wden, m_cnt, m_trig, m_warn, m_en, m_bact;
    int unsigned m_shadow [N];
    int unsigned m_active [N];
    bit          m_rd_pending;
    logic [31:0] exp_q [$];
    logic [32*N-1:0] mon_exp_f;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_state = S_IDLE; m_gain = 0; m_mask = 0; m_req = 0; m_wden = 1;
        m_cnt = 0; m_trig = 0; m_warn = 0; m_en = 0; m_bact = 0;
        m_rd_pending = 1'b0;
        for (int i = 0; i < N; i++) begin
            m_shadow[i] = FB + i * FS;
            m_active[i] = FB + i * FS;
        end
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] a);
        case (a)
            8'h00: return 32'((m_wden << 4) | m_req);
            8'h04: return 32'((m_en << 16) | (m_state << 4) | (m_warn << 2) | (m_trig << 1) | m_bact);
            8'h08: return 32'(m_mask);
            8'h0C: return 32'h0;
            default: begin
                for (int i = 0; i < N; i++)
                    if (a == 8'(16 + 4 * i)) return m_shadow[i];
                return 32'hDEAD_BEEF;
            end
        endcase
    endfunction

    // One clock of the controller, from the pre-edge model values and bus inputs.
    function automatic void model_step(input bit we, input logic [7:0] wa, input logic [31:0] wd);
        int o_state = m_state;
        int o_gain  = m_gain;
        int o_trig  = m_trig;
        int o_wden  = m_wden;
        int o_cnt   = m_cnt;
        bit go      = (m_req != 0) && (m_mask != 0) && (m_trig == 0);

        if (we && wa == 8'h00 && wd[5]) m_trig = 0;
        else if (o_wden != 0 && !we && o_cnt >= T - 1) m_trig = 1;

        if (we || o_wden == 0) m_cnt = 0;
        else if (o_trig == 0) m_cnt = o_cnt + 1;

        if (we) begin
            case (wa)
                8'h00: begin m_req = int'(wd[0]); m_wden = int'(wd[4]); end
                8'h08: m_mask = int'(wd) & ((1 << N) - 1);
                8'h0C: for (int i = 0; i < N; i++) m_active[i] = m_shadow[i];
                default: begin
                    for (int i = 0; i < N; i++) begin
                        if (wa == 8'(16 + 4 * i)) begin
                            m_shadow[i] = wd;
                            if (o_state == S_IDLE) m_active[i] = wd;
                        end
                    end
                end
            endcase
        end
        m_warn = (m_wden != 0 && m_cnt >= WARN) ? 1 : 0;

        if (o_trig != 0) begin
            m_state = S_FAULT;
            m_gain  = 0;
        end else begin
            case (o_state)
                S_IDLE: if (go) m_state = S_UP;
                S_UP: begin
                    if (!go) m_state = S_DOWN;
                    else begin
                        m_gain = (o_gain + STEP > GMAX) ? GMAX : o_gain + STEP;
                        if (m_gain == GMAX) m_state = S_ACT;
                    end
                end
                S_ACT: if (!go) m_state = S_DOWN;
                S_DOWN: begin
                    if (go) m_state = S_UP;
                    else begin
                        m_gain = (o_gain < STEP) ? 0 : o_gain - STEP;
                        if (m_gain == 0) m_state = S_IDLE;
                    end
                end
                default: m_state = S_IDLE;
            endcase
        end
        m_en   = (m_state inside {S_UP, S_ACT, S_DOWN}) ? m_mask : 0;
        m_bact = (m_state == S_ACT) ? 1 : 0;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic cycle(input bit we, input logic [7:0] wa, input logic [31:0] wd,
                         input bit re, input logic [7:0] ra);
        wr_en = we; wr_addr = wa; wr_data = wd;
        rd_en = re; rd_addr = ra;
        if (re) exp_q.push_back(model_read(ra));
        @(posedge clk);
        model_step(we, wa, wd);
        m_rd_pending = re;
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        cycle(1'b1, a, d, 1'b0, 8'h00);
    endtask

    task automatic rd(input logic [7:0] a);
        cycle(1'b0, 8'h00, 32'h0, 1'b1, a);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 8'h00, 32'h0, 1'b0, 8'h00);
    endtask

    function automatic logic [7:0] pick_addr();
        case ($urandom_range(0, 9))
            0: return 8'h00;
            1: return 8'h04;
            2: return 8'h08;
            3: return 8'h0C;
            4: return 8'h10;
            5: return 8'h14;
            6: return 8'h18;
            7: return 8'h30;
            8: return 8'h11;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    // ---------------- monitor / scoreboard ----------------
    initial begin
        forever begin
            @(negedge clk);
            check("rd_valid", 64'(rd_valid), 64'(m_rd_pending));
            if (rd_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rd_data: got 0x%0h with no read outstanding at %0t", rd_data, $time);
                end else begin
                    check("rd_data", 64'(rd_data), 64'(exp_q.pop_front()));
                end
            end
            for (int i = 0; i < N; i++) mon_exp_f[32*i +: 32] = m_active[i];
            check("gain",         64'(gain),         64'(m_gain));
            check("ch_enable",    64'(ch_enable),    64'(m_en));
            check("ch_freq",      64'(ch_freq),      64'(mon_exp_f));
            check("bcast_active", 64'(bcast_active), 64'(m_bact));
            check("wd_triggered", 64'(wd_triggered), 64'(m_trig));
            check("wd_warning",   64'(wd_warning),   64'(m_warn));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "time budget exceeded");
    end

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_en = 1'b0; rd_addr = '0;
        model_reset();
        #22;
        check("reset_gain",  64'(gain), 64'(0));
        check("reset_state", 64'(dut.state), 64'(S_IDLE));
        rst_n = 1'b1;

        // Reset contents of the register file.
        rd(8'h00); rd(8'h10); rd(8'h14); rd(8'h04); rd(8'h08);

        // Ramp up: gain 0 in the first RAMP_UP cycle, then 1..15.
        wr(8'h08, 32'h1);
        wr(8'h00, 32'h11);
        idle(15);
        check("ramp_up_gain14", 64'(gain), 64'(14));
        check("ramp_up_not_active", 64'(bcast_active), 64'(0));
        idle(1);
        check("ramp_up_gain_full", 64'(gain), 64'(GMAX));
        check("ramp_up_active", 64'(bcast_active), 64'(1));
        check("ramp_up_enable", 64'(ch_enable), 64'(1));
        rd(8'h04);

        // Ramp down: enable held until the gain reaches zero.
        wr(8'h00, 32'h10);
        idle(15);
        check("ramp_down_gain1", 64'(gain), 64'(1));
        check("ramp_down_enable_held", 64'(ch_enable), 64'(1));
        idle(1);
        check("ramp_down_gain0", 64'(gain), 64'(0));
        check("ramp_down_enable_off", 64'(ch_enable), 64'(0));
        rd(8'h04);

        // Watchdog: warning at count 80, trigger when count 99 is seen, hard cut next clock.
        wr(8'h00, 32'h11);
        idle(79);
        check("wd_warn_before", 64'(wd_warning), 64'(0));
        idle(1);
        check("wd_warn_at80", 64'(wd_warning), 64'(1));
        idle(19);
        check("wd_trig_before", 64'(wd_triggered), 64'(0));
        idle(1);
        check("wd_trig_set", 64'(wd_triggered), 64'(1));
        idle(1);
        check("fault_gain_cut", 64'(gain), 64'(0));
        check("fault_state", 64'(dut.state), 64'(S_FAULT));
        rd(8'h04);

        // Ordinary CTRL write does not clear the fault; wd_clear does.
        wr(8'h00, 32'h11);
        idle(2);
        check("fault_sticky", 64'(wd_triggered), 64'(1));
        rd(8'h04);
        wr(8'h00, 32'h31);
        idle(1);
        check("fault_exit_idle", 64'(dut.state), 64'(S_IDLE));
        idle(1);
        check("fault_rearm_rampup", 64'(dut.state), 64'(S_UP));
        rd(8'h00);
        idle(20);

        // Heartbeat on the very cycle the count reaches 99 wins.
        wr(8'h08, 32'h1);
        idle(99);
        wr(8'h08, 32'h1);
        idle(1);
        check("heartbeat_no_trig", 64'(wd_triggered), 64'(0));

        // Shadowed frequency update while on air, then commit.
        wr(8'h14, 32'd1_000_000);
        idle(1);
        check("shadow_hold", 64'(ch_freq[63:32]), 64'(900_000));
        rd(8'h14);
        wr(8'h0C, 32'h0);
        check("commit_applied", 64'(ch_freq[63:32]), 64'(1_000_000));
        rd(8'h30);

        // Mask to zero forces a ramp down; then an IDLE frequency write goes straight through.
        wr(8'h08, 32'h0);
        idle(20);
        check("mask0_idle", 64'(dut.state), 64'(S_IDLE));
        wr(8'h10, 32'd12_345);
        check("idle_freq_direct", 64'(ch_freq[31:0]), 64'(12_345));

        // Asynchronous reset in the middle of a ramp.
        wr(8'h08, 32'h3);
        wr(8'h00, 32'h11);
        idle(6);
        rst_n = 1'b0;
        model_reset();
        exp_q.delete();
        #2;
        check("async_rst_gain", 64'(gain), 64'(0));
        check("async_rst_state", 64'(dut.state), 64'(S_IDLE));
        check("async_rst_freq", 64'(ch_freq), {32'(FB + FS), 32'(FB)});
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // Randomized traffic with concurrent reads.
        for (int k = 0; k < 1500; k++) begin
            int          sel;
            bit          re;
            logic [7:0]  ra;
            logic [31:0] d;
            sel = $urandom_range(0, 99);
            re  = ($urandom_range(0, 2) == 0);
            ra  = pick_addr();
            d   = $urandom;
            if (sel < 15) begin
                d[0] = ($urandom_range(0, 3) != 0);
                d[4] = ($urandom_range(0, 7) != 0);
                d[5] = ($urandom_range(0, 7) == 0);
                cycle(1'b1, 8'h00, d, re, ra);
            end else if (sel < 25) begin
                cycle(1'b1, 8'h08, d, re, ra);
            end else if (sel < 35) begin
                cycle(1'b1, pick_addr(), d, re, ra);
            end else if (sel < 40) begin
                cycle(1'b1, 8'h0C, d, re, ra);
            end else if (sel < 98) begin
                cycle(1'b0, 8'h00, 32'h0, re, ra);
            end else begin
                idle(110);
            end
        end

        idle(3);
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
